// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the RF transceiver control blocks.
// Mode encoding is {M1, M0} as seen on the transceiver pins.
package rf_ctrl_pkg;

    localparam int NUM_MODULES = 3;
    localparam int IDX_W       = 2;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_NORMAL     = 2'b00;
    localparam mode_t MODE_WAKEUP     = 2'b01;
    localparam mode_t MODE_POWER_SAVE = 2'b10;
    localparam mode_t MODE_SLEEP      = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRE,
        SWITCH,
        WAIT_POST,
        DONE,
        FAIL
    } state_t;

endpackage

// File: rtl/rf_mode_scheduler_if.sv
// Host request/ack signals plus the transceiver mode pins for the scheduler.
// The slave modport is the scheduler's view; master is the host/board side.
interface rf_mode_scheduler_if #(
    parameter int N = rf_ctrl_pkg::NUM_MODULES
) ();
    logic [N-1:0]   req;
    logic [2*N-1:0] req_mode;
    logic [N-1:0]   ack;
    logic [N-1:0]   err;
    logic [N-1:0]   AUX;
    logic [N-1:0]   M0;
    logic [N-1:0]   M1;
    logic [2*N-1:0] cur_mode;
    logic           busy;

    modport master (
        output req, req_mode, AUX,
        input  ack, err, M0, M1, cur_mode, busy
    );

    modport slave (
        input  req, req_mode, AUX,
        output ack, err, M0, M1, cur_mode, busy
    );
endinterface

// File: rtl/rf_rr_arbiter.sv
// Round-robin arbiter: combinational grant starting at the pointer, pointer
// advances past the winner on each accepted grant.
module rf_rr_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int N  = NUM_MODULES,
    parameter int IW = IDX_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          grant_en,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;

    // Walk offsets from highest to lowest so the requester closest to the
    // pointer is the one left standing.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = int'(ptr_reg) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_en && grant_valid) begin
            ptr_next = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/rf_mode_scheduler.sv
// Serialises M0/M1 mode changes across the transceivers: wait for AUX idle,
// drive the new pins, let them settle, then wait for AUX to recover.
module rf_mode_scheduler
    import rf_ctrl_pkg::*;
#(
    parameter int NUM_MODULES   = rf_ctrl_pkg::NUM_MODULES,
    parameter int SETTLE_CYCLES = 15000,
    parameter int AUX_TIMEOUT   = 2500000,
    parameter int CNT_W         = 22
) (
    input  logic                device_clk,
    input  logic                rst,
    rf_mode_scheduler_if.slave  bus
);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(AUX_TIMEOUT - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [IDX_W-1:0]   g_reg;
    mode_t              m_reg;
    mode_t              cur_mode_reg [NUM_MODULES];
    mode_t              req_mode_arr [NUM_MODULES];
    logic [NUM_MODULES-1:0] aux_meta_reg;
    logic [NUM_MODULES-1:0] aux_s_reg;

    logic               grant_en;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               apply_mode;

    rf_rr_arbiter #(
        .N  (NUM_MODULES),
        .IW (IDX_W)
    ) u_arb (
        .clk         (device_clk),
        .rst         (rst),
        .req         (bus.req),
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_MODULES; gi++) begin : g_lane
            assign req_mode_arr[gi]        = bus.req_mode[2*gi +: 2];
            assign bus.cur_mode[2*gi +: 2] = cur_mode_reg[gi];
            assign bus.M0[gi]              = cur_mode_reg[gi][0];
            assign bus.M1[gi]              = cur_mode_reg[gi][1];
            assign bus.ack[gi] = (state_reg == DONE) && (g_reg == IDX_W'(gi));
            assign bus.err[gi] = (state_reg == FAIL) && (g_reg == IDX_W'(gi));
        end
    endgenerate

    assign bus.busy = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        grant_en   = 1'b0;
        apply_mode = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    grant_en   = 1'b1;
                    state_next = (req_mode_arr[grant_idx] == cur_mode_reg[grant_idx])
                               ? DONE : WAIT_PRE;
                end
            end
            WAIT_PRE: begin
                // A ready AUX wins over a simultaneous timeout.
                if (aux_s_reg[g_reg]) begin
                    state_next = SWITCH;
                    apply_mode = 1'b1;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = FAIL;
                end
            end
            SWITCH: begin
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = WAIT_POST;
                end
            end
            WAIT_POST: begin
                if (aux_s_reg[g_reg]) begin
                    state_next = DONE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = FAIL;
                end
            end
            DONE:    state_next = IDLE;
            FAIL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge device_clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            g_reg        <= '0;
            m_reg        <= MODE_NORMAL;
            aux_meta_reg <= '0;
            aux_s_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            aux_meta_reg <= bus.AUX;
            aux_s_reg    <= aux_meta_reg;
            if (grant_en) begin
                g_reg <= grant_idx;
                m_reg <= req_mode_arr[grant_idx];
            end
            // Counter restarts on every state entry and stays parked in IDLE.
            if ((state_next != state_reg) || (state_reg == IDLE)) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge device_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_MODULES; i++) begin
                cur_mode_reg[i] <= MODE_NORMAL;
            end
        end else if (apply_mode) begin
            cur_mode_reg[g_reg] <= m_reg;
        end
    end

endmodule

// File: tb/tb_rf_mode_scheduler.sv
// Bench for rf_mode_scheduler: table of single switches plus hand sequences
// for arbitration order, AUX stretch, same-mode and mid-switch reset.
module tb_rf_mode_scheduler;
    import rf_ctrl_pkg::*;

    localparam int S = 8;
    localparam int T = 32;

    logic device_clk = 1'b0;
    logic rst        = 1'b1;
    int   cyc        = 0;

    rf_mode_scheduler_if bus ();

    rf_mode_scheduler #(
        .NUM_MODULES   (3),
        .SETTLE_CYCLES (S),
        .AUX_TIMEOUT   (T),
        .CNT_W         (22)
    ) dut (
        .device_clk (device_clk),
        .rst        (rst),
        .bus        (bus)
    );

    always #5 device_clk = ~device_clk;
    always @(posedge device_clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] ack;
        logic [2:0] err;
        int         cyc;
        logic [5:0] cur;
    } exp_t;

    typedef struct {
        logic [2:0] req;
        logic [5:0] mode;
        logic [2:0] aux;
        logic [2:0] ack;
        logic [2:0] err;
        int         lat;
        logic [5:0] cur;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [2:0] m0_of(input logic [5:0] cur);
        return {cur[4], cur[2], cur[0]};
    endfunction

    function automatic logic [2:0] m1_of(input logic [5:0] cur);
        return {cur[5], cur[3], cur[1]};
    endfunction

    // Advance to the next falling edge and score any ack/err pulse there.
    task automatic tick();
        exp_t e;
        @(negedge device_clk);
        if ((bus.ack | bus.err) != 3'b000) begin
            $display("txn cycle=%0d ack=%b err=%b cur_mode=%b", cyc, bus.ack, bus.err, bus.cur_mode);
            chk("ack_err_exclusive", 32'((bus.ack != 0) && (bus.err != 0)), 32'd0);
            chk("pulse_onehot", 32'($countones(bus.ack | bus.err)), 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'(bus.ack | bus.err), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_ack", 32'(bus.ack), 32'(e.ack));
                chk("pulse_err", 32'(bus.err), 32'(e.err));
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_cur_mode", 32'(bus.cur_mode), 32'(e.cur));
            end
            bus.req = bus.req & ~(bus.ack | bus.err);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called at the falling edge where req is driven; lat is in spec cycles.
    task automatic expect_pulse(input logic [2:0] ack, input logic [2:0] err,
                                input int at_cyc, input logic [5:0] cur);
        exp_t e;
        e.ack = ack; e.err = err; e.cyc = at_cyc; e.cur = cur;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        ticks(2);
    endtask

    initial begin
        int c;
        bus.req      = '0;
        bus.req_mode = '0;
        bus.AUX      = '0;

        vecs[0] = '{3'b001, 6'b000001, 3'b111, 3'b001, 3'b000, S + 3, 6'b001101};
        vecs[1] = '{3'b100, 6'b100000, 3'b111, 3'b100, 3'b000, S + 3, 6'b101101};
        vecs[2] = '{3'b010, 6'b001100, 3'b111, 3'b010, 3'b000, 1,     6'b101101};
        vecs[3] = '{3'b001, 6'b010100, 3'b111, 3'b001, 3'b000, S + 3, 6'b101100};
        vecs[4] = '{3'b001, 6'b000001, 3'b110, 3'b000, 3'b001, T + 1, 6'b101100};
        vecs[5] = '{3'b100, 6'b110000, 3'b111, 3'b100, 3'b000, S + 3, 6'b111100};

        // Reset state
        ticks(2);
        chk("rst_M0", 32'(bus.M0), 32'd0);
        chk("rst_M1", 32'(bus.M1), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_cur_mode", 32'(bus.cur_mode), 32'd0);
        chk("rst_ack_err", 32'(bus.ack | bus.err), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.AUX = 3'($urandom_range(0, 7));
            tick();
            chk("idle_no_pulse", 32'(bus.ack | bus.err), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end
        bus.AUX = 3'b111;
        ticks(3);

        // Switch transceiver 1 to sleep; pins move on cycle 2.
        c = cyc;
        bus.req_mode = 6'b001100;
        bus.req      = 3'b010;
        expect_pulse(3'b010, 3'b000, c + S + 3, 6'b001100);
        tick();
        chk("a_busy_c1", 32'(bus.busy), 32'd1);
        chk("a_M0_c1", 32'(bus.M0[1]), 32'd0);
        tick();
        chk("a_M0_c2", 32'(bus.M0[1]), 32'd1);
        chk("a_M1_c2", 32'(bus.M1[1]), 32'd1);
        drain(100);

        // Table of single switches
        for (int v = 0; v < 6; v++) begin
            bus.AUX = vecs[v].aux;
            ticks(3);
            c = cyc;
            bus.req_mode = vecs[v].mode;
            bus.req      = vecs[v].req;
            expect_pulse(vecs[v].ack, vecs[v].err, c + vecs[v].lat, vecs[v].cur);
            drain(100);
            chk("vec_M0", 32'(bus.M0), 32'(m0_of(vecs[v].cur)));
            chk("vec_M1", 32'(bus.M1), 32'(m1_of(vecs[v].cur)));
            chk("vec_idle", 32'(bus.busy), 32'd0);
        end
        bus.AUX = 3'b111;
        ticks(3);

        // All three at once: grants 0, 1, 2 with one IDLE cycle between.
        c = cyc;
        bus.req_mode = 6'b011001;
        bus.req      = 3'b111;
        expect_pulse(3'b001, 3'b000, c + 11, 6'b111101);
        expect_pulse(3'b010, 3'b000, c + 23, 6'b111001);
        expect_pulse(3'b100, 3'b000, c + 35, 6'b011001);
        drain(200);

        // Pointer is back at 0, so 0 beats 2.
        c = cyc;
        bus.req_mode = 6'b001010;
        bus.req      = 3'b101;
        expect_pulse(3'b001, 3'b000, c + 11, 6'b011010);
        expect_pulse(3'b100, 3'b000, c + 23, 6'b001010);
        drain(200);

        // AUX[2] held low through 5 WAIT_POST cycles.
        c = cyc;
        bus.req_mode = 6'b110000;
        bus.req      = 3'b100;
        expect_pulse(3'b100, 3'b000, c + S + 3 + 5, 6'b111010);
        ticks(3);
        bus.AUX[2] = 1'b0;
        ticks(10);
        bus.AUX[2] = 1'b1;
        drain(100);

        // Same-mode request: ack on cycle 1, pins untouched.
        c = cyc;
        bus.req_mode = 6'b001000;
        bus.req      = 3'b010;
        expect_pulse(3'b010, 3'b000, c + 1, 6'b111010);
        tick();
        chk("same_M0", 32'(bus.M0), 32'b100);
        chk("same_M1", 32'(bus.M1), 32'b111);
        drain(20);

        // Reset in the middle of SWITCH: pins drop, no ack follows.
        bus.req_mode = 6'b000011;
        bus.req      = 3'b001;
        ticks(4);
        chk("e_M0_switch", 32'(bus.M0), 32'b101);
        chk("e_busy_switch", 32'(bus.busy), 32'd1);
        rst     = 1'b1;
        bus.req = 3'b000;
        tick();
        chk("e_rst_M0", 32'(bus.M0), 32'd0);
        chk("e_rst_M1", 32'(bus.M1), 32'd0);
        chk("e_rst_cur_mode", 32'(bus.cur_mode), 32'd0);
        chk("e_rst_busy", 32'(bus.busy), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("e_no_pulse", 32'(bus.ack | bus.err), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rf_mode_scheduler.md
# rf_mode_scheduler

Mode-switch sequencer and arbiter for the three-transceiver RF array. It takes mode-change requests for up to three E32-style transceivers and drives their M0/M1 pins, one transceiver at a time. Each switch waits for AUX idle, applies the new pins, waits a settle interval and then waits for AUX to recover. It sits between the host/MCU control logic and the M0_n/M1_n/AUX_n pins of the multi-transceiver top level.

## Interface
Parameters:
- NUM_MODULES, 3, number of transceivers served (fixed 3 in this revision)
- SETTLE_CYCLES, 15000, cycles the pins are held before AUX is re-checked
- AUX_TIMEOUT, 2500000, maximum cycles spent waiting for AUX high in either wait state
- CNT_W, 22, counter width; must satisfy 2^CNT_W > max(SETTLE_CYCLES, AUX_TIMEOUT)

Ports:
- device_clk  in  1  single system clock
- rst  in  1  asynchronous, active-high reset
- req  in  3  level request per transceiver; held until ack or err
- req_mode  in  6  requested mode; bits [2n+1:2n] for transceiver n; bit 1 = M1, bit 0 = M0
- ack  out  3  one-cycle pulse when the switch completes
- err  out  3  one-cycle pulse when the switch times out
- AUX  in  3  raw AUX pins (asynchronous); high = idle
- M0  out  3  M0 pin per transceiver
- M1  out  3  M1 pin per transceiver
- cur_mode  out  6  last mode driven per transceiver
- busy  out  1  high in every state except IDLE

## Operation
- AUX passes through a 2-flop synchronizer per bit (aux_s). All FSM decisions use aux_s.
- States:
  - IDLE: if any req is high, grant one requester round-robin, latch its index g and its req_mode slice m.
    - If m == cur_mode[g], go to DONE.
    - Otherwise go to WAIT_PRE.
  - WAIT_PRE: wait for aux_s[g] high, then go to SWITCH. On the same edge, update M0[g], M1[g] and cur_mode[g] to m and clear the counter.
    - If the counter reaches AUX_TIMEOUT-1, go to FAIL. Pins are untouched.
  - SWITCH: count SETTLE_CYCLES cycles, then go to WAIT_POST.
  - WAIT_POST: wait for aux_s[g] high, then go to DONE.
    - If the counter reaches AUX_TIMEOUT-1, go to FAIL. The new mode remains applied.
  - DONE: ack[g] = 1 for one cycle, then go to IDLE.
  - FAIL: err[g] = 1 for one cycle, then go to IDLE.
- Round-robin: a pointer p resets to 0.
  - Priority order is p, p+1, p+2 (mod 3).
  - After a grant to g, p becomes (g+1) mod 3.
- req deasserting after grant is ignored: the sequence completes and ack/err still pulses. req_mode is sampled only at grant.
- Only the granted transceiver's pins change. The others hold their values.
- Reset values:
  - M0 = M1 = 0 (normal mode), cur_mode = 0.
  - ack = err = 0, busy = 0.
  - State IDLE, p = 0, counter 0, synchronizers 0.
- Reset mid-operation aborts the sequence immediately, returns the pins to normal mode and produces no ack/err.

## Timing
- Counter clears on every state entry.
- Grant edge = cycle 0.
- With aux_s already high, WAIT_PRE and WAIT_POST each take 1 cycle. SWITCH takes exactly SETTLE_CYCLES cycles. ack is high in cycle SETTLE_CYCLES+3.
- The pins change on the edge entering SWITCH (cycle 2).
- Same-mode request: ack is high in cycle 1.
- Timeout in WAIT_PRE: err is high in cycle AUX_TIMEOUT+1.
- AUX input-to-decision latency is 2 cycles from the synchronizer.
- The earliest next grant is the edge after DONE/FAIL, since IDLE must be re-entered. Back-to-back requests are therefore spaced by at least 1 IDLE cycle.
- ack and err are never high together, and at most one bit of either is high at a time.

## Structure
- Package rf_ctrl_pkg holds:
  - the state enum (IDLE, WAIT_PRE, SWITCH, WAIT_POST, DONE, FAIL);
  - mode constants MODE_NORMAL = 2'b00, MODE_WAKEUP = 2'b01, MODE_POWER_SAVE = 2'b10, MODE_SLEEP = 2'b11;
  - the NUM_MODULES default.
- Sub-module rf_rr_arbiter: combinational grant from req and p, plus a registered pointer update on a grant-enable input. It is reusable for the later UART-sharing block.
- The synchronizer and counter stay inline.

## Test plan
Bench uses SETTLE_CYCLES = 8 and AUX_TIMEOUT = 32.
- Reset, then hold: M0 = M1 = 0, busy = 0, cur_mode = 0; any AUX pattern causes no ack/err.
- req = 3'b010, req_mode[3:2] = 2'b11, AUX = 3'b111: M0[1] = M1[1] = 1 at cycle 2; ack = 3'b010 for one cycle at cycle 11; cur_mode[3:2] = 2'b11.
- All three req high together, distinct modes, AUX high: grants in order 0, 1, 2; three ack pulses; then req 0 and 2 again → grant 0 first (p = 0 after grant 2).
- AUX[0] held low, req[0] with mode 2'b01: err = 3'b001 at cycle 33; M0[0] stays 0; cur_mode unchanged.
- AUX[2] low during WAIT_POST, released after 5 cycles: ack[2] delayed by exactly 5 cycles relative to the always-high run.
- Same-mode request (req_mode = cur_mode): ack at cycle 1 with no pin toggle. Separately, assert rst during SWITCH: all pins return to 0, no ack.
